// File: rtl/cthorens_cpu_pkg.sv
// Shared types for the cthorens CPU: opcodes, FSM states, flag struct, instruction field helpers.
// No logic and no latency; backpressure: none.
package cthorens_cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_ADDI = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_JNZ  = 4'hB,
        OP_CMP  = 4'hC,
        OP_MUL  = 4'hD,
        OP_RSVD = 4'hE,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef struct packed {
        logic z;
        logic c;
    } flags_t;

    // Instruction layout, MSB first: op[3:0] | rd | rs | imm[DATA_W-1:0]
    function automatic int rd_lsb(input int data_w, input int ra_w);
        return data_w + ra_w;
    endfunction

    function automatic int rs_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic logic branch_taken(input op_e op, input logic z);
        return (op == OP_JMP) || ((op == OP_JZ) && z) || ((op == OP_JNZ) && !z);
    endfunction

endpackage

// File: rtl/cthorens_cpu_alu.sv
// Combinational ALU: (op, a, b, imm) -> result, Z/C flags, register and flag write enables.
// Latency: 0 cycles. Backpressure: none. Op D is a multiply only when CTHORENS_CPU_MUL_EN is defined.
module cthorens_cpu_alu
    import cthorens_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c,
    output logic              wr_en,
    output logic              fl_en
);

    logic [DATA_W:0] sum_ab;
    logic [DATA_W:0] sum_ai;
    logic [DATA_W:0] diff;

    assign sum_ab = {1'b0, a} + {1'b0, b};
    assign sum_ai = {1'b0, a} + {1'b0, imm};
    // The extra MSB of the widened difference is exactly the borrow (a < b).
    assign diff   = {1'b0, a} - {1'b0, b};

`ifdef CTHORENS_CPU_MUL_EN
    logic [2*DATA_W-1:0] prod;
    assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    always_comb begin
        result = '0;
        c      = 1'b0;
        wr_en  = 1'b0;
        fl_en  = 1'b0;
        case (op)
            OP_LDI:  begin result = imm; wr_en = 1'b1; end
            OP_MOV:  begin result = b;   wr_en = 1'b1; end
            OP_ADD:  begin {c, result} = sum_ab; wr_en = 1'b1; fl_en = 1'b1; end
            OP_SUB:  begin {c, result} = diff;   wr_en = 1'b1; fl_en = 1'b1; end
            OP_AND:  begin result = a & b; wr_en = 1'b1; fl_en = 1'b1; end
            OP_OR:   begin result = a | b; wr_en = 1'b1; fl_en = 1'b1; end
            OP_XOR:  begin result = a ^ b; wr_en = 1'b1; fl_en = 1'b1; end
            OP_ADDI: begin {c, result} = sum_ai; wr_en = 1'b1; fl_en = 1'b1; end
            OP_CMP:  begin {c, result} = diff;   fl_en = 1'b1; end
`ifdef CTHORENS_CPU_MUL_EN
            OP_MUL:  begin
                result = prod[DATA_W-1:0];
                c      = |prod[2*DATA_W-1:DATA_W];
                wr_en  = 1'b1;
                fl_en  = 1'b1;
            end
`endif
            default: ;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/cthorens_cpu_core.sv
// Multi-cycle register CPU: FETCH -> EXEC -> WB, HALT absorbing; external sync-read ROM.
// Latency: exactly 3 cycles per instruction, o_RETIRE pulses in WB. Backpressure: none.
// Define CTHORENS_CPU_MUL_EN to turn opcode D into a multiply (otherwise it retires as a NOP).
module cthorens_cpu_core
    import cthorens_cpu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NREGS   = 4,
    parameter  int PC_W    = 8,
    parameter  int OUT_REG = 3,
    localparam int RA_W    = $clog2(NREGS),
    localparam int INSTR_W = 4 + 2*RA_W + DATA_W
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    output logic [PC_W-1:0]    o_PC,
    input  logic [INSTR_W-1:0] i_INSTR,
    output logic [DATA_W-1:0]  o_REG_OUT,
    output logic               o_RETIRE,
    output logic               o_HALTED
);

    localparam int             RD_LSB = rd_lsb(DATA_W, RA_W);
    localparam int             RS_LSB = rs_lsb(DATA_W);
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_e             state, state_nxt;
    logic [PC_W-1:0]    pc, pc_nxt;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [NREGS];
    flags_t             flags;

    // EXEC results held for the WB cycle
    logic [DATA_W-1:0]  res_q;
    flags_t             res_flags_q;
    logic               wr_q;
    logic               fl_q;

    // EXEC decodes straight off the ROM output, which is valid this cycle
    op_e               ex_op;
    logic [RA_W-1:0]   ex_rd, ex_rs;
    logic [DATA_W-1:0] ex_imm;

    assign ex_op  = op_e'(i_INSTR[INSTR_W-1 -: 4]);
    assign ex_rd  = i_INSTR[RD_LSB +: RA_W];
    assign ex_rs  = i_INSTR[RS_LSB +: RA_W];
    assign ex_imm = i_INSTR[DATA_W-1:0];

    op_e               wb_op;
    logic [RA_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_imm;
    logic              unused_ir_rs;

    assign wb_op        = op_e'(ir[INSTR_W-1 -: 4]);
    assign wb_rd        = ir[RD_LSB +: RA_W];
    assign wb_imm       = ir[DATA_W-1:0];
    assign unused_ir_rs = ^ir[RS_LSB +: RA_W];

    logic [DATA_W-1:0] alu_res;
    logic              alu_z, alu_c, alu_wr, alu_fl;

    cthorens_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (ex_op),
        .a      (regs[ex_rd]),
        .b      (regs[ex_rs]),
        .imm    (ex_imm),
        .result (alu_res),
        .z      (alu_z),
        .c      (alu_c),
        .wr_en  (alu_wr),
        .fl_en  (alu_fl)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= S_FETCH;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_WB;
            S_WB: begin
                if (wb_op == OP_HALT) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_FETCH;
                    pc_nxt    = branch_taken(wb_op, flags.z) ? wb_imm[PC_W-1:0] : pc + PC_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            ir          <= '0;
            flags       <= '0;
            res_q       <= '0;
            res_flags_q <= '0;
            wr_q        <= 1'b0;
            fl_q        <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == S_EXEC) begin
                ir          <= i_INSTR;
                res_q       <= alu_res;
                res_flags_q <= '{z: alu_z, c: alu_c};
                wr_q        <= alu_wr;
                fl_q        <= alu_fl;
            end
            if (state == S_WB) begin
                if (wr_q) begin
                    regs[wb_rd] <= res_q;
                end
                if (fl_q) begin
                    flags <= res_flags_q;
                end
            end
        end
    end

    assign o_PC      = pc;
    assign o_REG_OUT = regs[OUT_REG];
    assign o_RETIRE  = (state == S_WB);
    assign o_HALTED  = (state == S_HALT);

endmodule

// File: tb/tb_cthorens_cpu_core.sv
// Bench for cthorens_cpu_core at default parameters: an instruction-level reference model
// retires each ROM instruction and is compared against the core after every write-back.
module tb_cthorens_cpu_core;

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b1;
    logic [7:0]  o_PC;
    logic [15:0] i_INSTR;
    logic [7:0]  o_REG_OUT;
    logic        o_RETIRE;
    logic        o_HALTED;

    logic [15:0] rom [256];

    int vectors     = 0;
    int miscompares = 0;

    // architectural reference state
    int m_r [4];
    int m_z, m_c, m_pc, m_halted;

    cthorens_cpu_core dut (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .o_PC      (o_PC),
        .i_INSTR   (i_INSTR),
        .o_REG_OUT (o_REG_OUT),
        .o_RETIRE  (o_RETIRE),
        .o_HALTED  (o_HALTED)
    );

    always #5 i_CLK = ~i_CLK;

    always @(posedge i_CLK) i_INSTR <= rom[o_PC];

    function automatic logic [15:0] enc(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_z = 0; m_c = 0; m_pc = 0; m_halted = 0;
    endtask

    task automatic model_exec(input logic [15:0] ins);
        int op, rd, rs, imm, a, b, s, nxt;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:10]);
        rs  = int'(ins[9:8]);
        imm = int'(ins[7:0]);
        a   = m_r[rd];
        b   = m_r[rs];
        nxt = (m_pc + 1) % 256;
        case (op)
            1:  m_r[rd] = imm;
            2:  m_r[rd] = b;
            3:  begin s = a + b;   m_c = (s > 255); m_r[rd] = s % 256; m_z = (m_r[rd] == 0); end
            4:  begin m_c = (a < b); m_r[rd] = (a - b + 256) % 256; m_z = (m_r[rd] == 0); end
            5:  begin m_r[rd] = a & b; m_c = 0; m_z = (m_r[rd] == 0); end
            6:  begin m_r[rd] = a | b; m_c = 0; m_z = (m_r[rd] == 0); end
            7:  begin m_r[rd] = a ^ b; m_c = 0; m_z = (m_r[rd] == 0); end
            8:  begin s = a + imm; m_c = (s > 255); m_r[rd] = s % 256; m_z = (m_r[rd] == 0); end
            9:  nxt = imm;
            10: if (m_z != 0) nxt = imm;
            11: if (m_z == 0) nxt = imm;
            12: begin m_c = (a < b); m_z = (a == b); end
`ifdef CTHORENS_CPU_MUL_EN
            13: begin s = a * b; m_r[rd] = s % 256; m_c = (s >= 256); m_z = (m_r[rd] == 0); end
`endif
            15: begin m_halted = 1; nxt = m_pc; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic do_reset();
        i_RST = 1'b1;
        repeat (3) @(negedge i_CLK);
        vectors++;
        if (o_PC !== 8'h00 || o_REG_OUT !== 8'h00 || o_RETIRE !== 1'b0 ||
            o_HALTED !== 1'b0 || dut.flags !== 2'b00) begin
            miscompares++;
            $display("FAIL reset: pc=%h reg_out=%h retire=%b halted=%b zc=%b, required 00 00 0 0 00",
                     o_PC, o_REG_OUT, o_RETIRE, o_HALTED, dut.flags);
        end
        i_RST = 1'b0;
        model_reset();
    endtask

    // Called at a negedge inside FETCH; returns at the negedge after that instruction's WB.
    task automatic step_instr();
        int waited;
        waited = 0;
        while (o_RETIRE !== 1'b1 && waited < 8) begin
            @(negedge i_CLK);
            waited++;
        end
        vectors++;
        if (waited != 2) begin
            miscompares++;
            $display("FAIL retire_cadence: pc=%0d retire after %0d cycles, required 2", m_pc, waited);
            if (o_RETIRE !== 1'b1) return;
        end
        vectors++;
        if (o_PC !== 8'(m_pc)) begin
            miscompares++;
            $display("FAIL fetch_addr: o_PC=%h, required %h", o_PC, 8'(m_pc));
        end
        model_exec(rom[m_pc]);
        @(negedge i_CLK);
        vectors++;
        if (o_PC !== 8'(m_pc) || o_REG_OUT !== 8'(m_r[3]) || dut.flags.z !== 1'(m_z) ||
            dut.flags.c !== 1'(m_c) || o_RETIRE !== 1'b0 || o_HALTED !== 1'(m_halted)) begin
            miscompares++;
            $display("FAIL post_wb: pc=%h reg_out=%h z=%b c=%b retire=%b halted=%b, required %h %h %0d %0d 0 %0d",
                     o_PC, o_REG_OUT, dut.flags.z, dut.flags.c, o_RETIRE, o_HALTED,
                     8'(m_pc), 8'(m_r[3]), m_z, m_c, m_halted);
        end
    endtask

    task automatic check_halt();
        for (int i = 0; i < 5; i++) begin
            @(negedge i_CLK);
            vectors++;
            if (o_HALTED !== 1'b1 || o_PC !== 8'(m_pc) || o_RETIRE !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_hold: halted=%b pc=%h retire=%b, required 1 %h 0",
                         o_HALTED, o_PC, o_RETIRE, 8'(m_pc));
            end
        end
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n && m_halted == 0; i++) step_instr();
        if (m_halted != 0) check_halt();
    endtask

    task automatic test_reset();
        rom_clear();
        rom[0] = enc(1, 3, 0, 8'h55);
        rom[1] = enc(1, 3, 0, 8'hAA);
        rom[2] = enc(8, 3, 0, 8'h01);
        rom[3] = enc(9, 0, 0, 8'h02);
        do_reset();
        run_steps(2);
        @(negedge i_CLK);                // now mid-instruction (EXEC of ADDI)
        do_reset();
        run_steps(1);
        vectors++;
        if (o_REG_OUT !== 8'h55 || o_PC !== 8'h01) begin
            miscompares++;
            $display("FAIL reset_restart: reg_out=%h pc=%h, required 55 01", o_REG_OUT, o_PC);
        end
    endtask

    task automatic test_addi();
        rom_clear();
        rom[0] = enc(1, 3, 0, 8'h7F);
        rom[1] = enc(8, 3, 0, 8'h01);
        rom[2] = enc(8, 3, 0, 8'h80);
        rom[3] = enc(15, 0, 0, 0);
        do_reset();
        run_steps(2);
        vectors++;
        if (o_REG_OUT !== 8'h80 || dut.flags !== 2'b00) begin
            miscompares++;
            $display("FAIL addi_80: reg_out=%h zc=%b, required 80 00", o_REG_OUT, dut.flags);
        end
        run_steps(1);
        vectors++;
        if (o_REG_OUT !== 8'h00 || dut.flags !== 2'b11) begin
            miscompares++;
            $display("FAIL addi_wrap: reg_out=%h zc=%b, required 00 11", o_REG_OUT, dut.flags);
        end
        run_steps(4);
    endtask

    task automatic test_loop();
        rom_clear();
        rom[0] = enc(1, 0, 0, 5);
        rom[1] = enc(1, 3, 0, 0);
        rom[2] = enc(8, 3, 0, 2);
        rom[3] = enc(8, 0, 0, 8'hFF);
        rom[4] = enc(11, 0, 0, 2);
        rom[5] = enc(15, 0, 0, 0);
        do_reset();
        run_steps(40);
        vectors++;
        if (o_REG_OUT !== 8'd10 || o_HALTED !== 1'b1 || o_PC !== 8'h05) begin
            miscompares++;
            $display("FAIL loop: reg_out=%0d halted=%b pc=%h, required 10 1 05", o_REG_OUT, o_HALTED, o_PC);
        end
    endtask

    task automatic test_sub_cmp();
        rom_clear();
        rom[0] = enc(1, 1, 0, 3);
        rom[1] = enc(1, 2, 0, 5);
        rom[2] = enc(12, 1, 2, 0);
        rom[3] = enc(2, 3, 1, 0);
        rom[4] = enc(4, 1, 1, 0);
        rom[5] = enc(2, 3, 1, 0);
        rom[6] = enc(15, 0, 0, 0);
        do_reset();
        run_steps(4);
        vectors++;
        if (o_REG_OUT !== 8'h03 || dut.flags !== 2'b01) begin
            miscompares++;
            $display("FAIL cmp: r1=%h zc=%b, required 03 01", o_REG_OUT, dut.flags);
        end
        run_steps(2);
        vectors++;
        if (o_REG_OUT !== 8'h00 || dut.flags !== 2'b10) begin
            miscompares++;
            $display("FAIL sub_self: r1=%h zc=%b, required 00 10", o_REG_OUT, dut.flags);
        end
        run_steps(4);
    endtask

    task automatic test_pc_wrap();
        rom_clear();
        rom[0]   = enc(9, 0, 0, 8'hFF);
        rom[255] = enc(0, 0, 0, 0);
        do_reset();
        run_steps(1);
        vectors++;
        if (o_PC !== 8'hFF) begin
            miscompares++;
            $display("FAIL jmp_ff: o_PC=%h, required ff", o_PC);
        end
        run_steps(1);
        vectors++;
        if (o_PC !== 8'h00) begin
            miscompares++;
            $display("FAIL pc_wrap: o_PC=%h, required 00", o_PC);
        end
        run_steps(2);
    endtask

    task automatic test_mul();
        rom_clear();
        rom[0] = enc(1, 3, 0, 8'h10);
        rom[1] = enc(1, 1, 0, 8'h11);
        rom[2] = enc(1, 2, 0, 8'h80);
        rom[3] = enc(8, 2, 0, 8'h80);
        rom[4] = enc(13, 3, 1, 0);
        rom[5] = enc(15, 0, 0, 0);
        do_reset();
        run_steps(5);
        vectors++;
`ifdef CTHORENS_CPU_MUL_EN
        if (o_REG_OUT !== 8'h10 || dut.flags !== 2'b01 || o_PC !== 8'h05) begin
            miscompares++;
            $display("FAIL mul: r3=%h zc=%b pc=%h, required 10 01 05", o_REG_OUT, dut.flags, o_PC);
        end
`else
        if (o_REG_OUT !== 8'h10 || dut.flags !== 2'b11 || o_PC !== 8'h05) begin
            miscompares++;
            $display("FAIL mul_as_nop: r3=%h zc=%b pc=%h, required 10 11 05", o_REG_OUT, dut.flags, o_PC);
        end
`endif
        run_steps(4);
    endtask

    task automatic test_random();
        for (int pass = 0; pass < 3; pass++) begin
            for (int i = 0; i < 256; i++) begin
                rom[i] = enc($urandom_range(0, 14), $urandom_range(0, 3),
                             $urandom_range(0, 3), $urandom_range(0, 255));
            end
            do_reset();
            run_steps(150);
        end
    endtask

    initial begin
        i_INSTR = 16'h0000;
        rom_clear();
        test_reset();
        test_addi();
        test_loop();
        test_sub_cmp();
        test_pc_wrap();
        test_mul();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
